// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU fetch port and the data port.
// Define IFETCH_BUF_EN to add a one-entry fetch buffer that serves repeated fetches without a bus access.
module mem_arbiter #(
   parameter int          MODE_W   = 2,
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              iReq,
   input  logic [31:0]       iAddr,
   output logic              iValid,
   output logic [31:0]       iRdata,
   input  logic              dReq,
   input  logic              dWrite,
   input  logic [31:0]       dAddr,
   input  logic [31:0]       dWdata,
   input  logic [MODE_W-1:0] dMode,
   output logic              dValid,
   output logic [31:0]       dRdata,
   output logic              stall,
   output logic              mReq,
   output logic              mWrite,
   output logic [31:0]       mAddr,
   output logic [31:0]       mWdata,
   output logic [MODE_W-1:0] mMode,
   input  logic              mAck,
   input  logic [31:0]       mRdata,
   output logic              busErr
);

   localparam logic [1:0]        ST_IDLE   = 2'd0;
   localparam logic [1:0]        ST_DATA   = 2'd1;
   localparam logic [1:0]        ST_INST   = 2'd2;
   localparam logic [MODE_W-1:0] MODE_WORD = MODE_W'(2'b10);
   localparam int                WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0]   WD_LAST   = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : {WD_W{1'b0}};
   localparam logic              WD_EN     = (TIMEOUT > 0) ? 1'b1 : 1'b0;

   logic [1:0]        state_q,     state_d;
   logic              last_inst_q, last_inst_d;
   logic [WD_W-1:0]   wd_q,        wd_d;
   logic              m_req_q,     m_req_d;
   logic              m_write_q,   m_write_d;
   logic [31:0]       m_addr_q,    m_addr_d;
   logic [31:0]       m_wdata_q,   m_wdata_d;
   logic [MODE_W-1:0] m_mode_q,    m_mode_d;
   logic              i_valid_q,   i_valid_d;
   logic              d_valid_q,   d_valid_d;
   logic [31:0]       i_rdata_q,   i_rdata_d;
   logic [31:0]       d_rdata_q,   d_rdata_d;
   logic              bus_err_q,   bus_err_d;
`ifdef IFETCH_BUF_EN
   logic [31:0]       buf_tag_q,   buf_tag_d;
   logic [31:0]       buf_data_q,  buf_data_d;
   logic              buf_vld_q,   buf_vld_d;
`endif

   logic i_pend_s, d_pend_s, grant_d_s, grant_i_s, hit_s, ack_s, timeout_s;

   // A port's own request is ignored while its completion pulse is showing.
   assign i_pend_s  = iReq & ~i_valid_q;
   assign d_pend_s  = dReq & ~d_valid_q;
   assign grant_d_s = d_pend_s & (~i_pend_s | last_inst_q);
   assign grant_i_s = i_pend_s & (~d_pend_s | ~last_inst_q);
   assign ack_s     = m_req_q & mAck;
   assign timeout_s = WD_EN & m_req_q & ~mAck & (wd_q == WD_LAST);
`ifdef IFETCH_BUF_EN
   assign hit_s     = grant_i_s & buf_vld_q & (iAddr == buf_tag_q);
`else
   assign hit_s     = 1'b0;
`endif

   assign stall  = i_pend_s | d_pend_s;
   assign iValid = i_valid_q;
   assign iRdata = i_rdata_q;
   assign dValid = d_valid_q;
   assign dRdata = d_rdata_q;
   assign mReq   = m_req_q;
   assign mWrite = m_write_q;
   assign mAddr  = m_addr_q;
   assign mWdata = m_wdata_q;
   assign mMode  = m_mode_q;
   assign busErr = bus_err_q;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= ST_IDLE;
         last_inst_q <= 1'b1;
         wd_q        <= {WD_W{1'b0}};
         m_req_q     <= 1'b0;
         m_write_q   <= 1'b0;
         m_addr_q    <= 32'h0;
         m_wdata_q   <= 32'h0;
         m_mode_q    <= {MODE_W{1'b0}};
         i_valid_q   <= 1'b0;
         d_valid_q   <= 1'b0;
         i_rdata_q   <= 32'h0;
         d_rdata_q   <= 32'h0;
         bus_err_q   <= 1'b0;
`ifdef IFETCH_BUF_EN
         buf_tag_q   <= 32'h0;
         buf_data_q  <= 32'h0;
         buf_vld_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_inst_q <= last_inst_d;
         wd_q        <= wd_d;
         m_req_q     <= m_req_d;
         m_write_q   <= m_write_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         m_mode_q    <= m_mode_d;
         i_valid_q   <= i_valid_d;
         d_valid_q   <= d_valid_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         bus_err_q   <= bus_err_d;
`ifdef IFETCH_BUF_EN
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
         buf_vld_q   <= buf_vld_d;
`endif
      end
   end

   // Next-state logic; a busy state with mReq already dropped is the post-timeout cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_d_s) begin
               state_d = ST_DATA;
            end else if (grant_i_s && !hit_s) begin
               state_d = ST_INST;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DATA, ST_INST: begin
            if (ack_s || !m_req_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus sequencing, completion pulses, read-data capture and watchdog.
   always_comb begin
      last_inst_d = last_inst_q;
      wd_d        = wd_q;
      m_req_d     = m_req_q;
      m_write_d   = m_write_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      m_mode_d    = m_mode_q;
      i_valid_d   = 1'b0;
      d_valid_d   = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      bus_err_d   = 1'b0;
`ifdef IFETCH_BUF_EN
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      buf_vld_d   = buf_vld_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_d_s) begin
               m_req_d   = 1'b1;
               m_write_d = dWrite;
               m_addr_d  = dAddr;
               m_wdata_d = dWdata;
               m_mode_d  = dMode;
               wd_d      = {WD_W{1'b0}};
`ifdef IFETCH_BUF_EN
               if (dWrite && buf_vld_q && (dAddr[31:2] == buf_tag_q[31:2])) begin
                  buf_vld_d = 1'b0;
               end else begin
                  buf_vld_d = buf_vld_q;
               end
`endif
            end
`ifdef IFETCH_BUF_EN
            else if (hit_s) begin
               i_valid_d = 1'b1;
               i_rdata_d = buf_data_q;
            end
`endif
            else if (grant_i_s) begin
               m_req_d   = 1'b1;
               m_write_d = 1'b0;
               m_addr_d  = iAddr;
               m_wdata_d = 32'h0;
               m_mode_d  = MODE_WORD;
               wd_d      = {WD_W{1'b0}};
            end else begin
               m_req_d   = 1'b0;
            end
         end
         ST_DATA, ST_INST: begin
            if (!m_req_q) begin
               last_inst_d = (state_q == ST_INST);
               if (state_q == ST_INST) begin
                  i_valid_d = 1'b1;
                  i_rdata_d = ERR_DATA;
               end else begin
                  d_valid_d = 1'b1;
                  d_rdata_d = ERR_DATA;
               end
            end else if (mAck) begin
               m_req_d     = 1'b0;
               last_inst_d = (state_q == ST_INST);
               if (state_q == ST_INST) begin
                  i_valid_d  = 1'b1;
                  i_rdata_d  = mRdata;
`ifdef IFETCH_BUF_EN
                  buf_tag_d  = m_addr_q;
                  buf_data_d = mRdata;
                  buf_vld_d  = 1'b1;
`endif
               end else begin
                  d_valid_d = 1'b1;
                  d_rdata_d = m_write_q ? 32'h0 : mRdata;
               end
            end else if (timeout_s) begin
               m_req_d   = 1'b0;
               bus_err_d = 1'b1;
            end else begin
               wd_d = WD_EN ? (wd_q + WD_W'(1)) : wd_q;
            end
         end
         default: m_req_d = 1'b0;
      endcase
   end

endmodule
